// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for the bit-serial subtractor.
// Valid/ready rules for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high. The producer keeps valid and its
// data stable until that edge. Ready never depends combinationally on valid.
interface serial_subtractor_if #(
  parameter int N = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         bout;

  // Operand producer and result consumer (testbench or upstream logic)
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
  );

  // The subtractor itself
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell and a borrow flop do all the arithmetic.
// Only one operation is in flight: IDLE accepts, RUN takes N cycles, and DONE
// presents the result until it is popped.
module serial_subtractor #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus,
  output logic [1:0]           o_state
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_a_sr;
  logic [N-1:0]   r_b_sr;
  logic [N-1:0]   r_d_sr;
  logic [N-1:0]   r_diff;
  logic           r_brw;
  logic           r_bout;
  logic [CW-1:0]  r_cnt;

  logic           w_accept;
  logic           w_last;
  logic           w_d;
  logic           w_brw_nxt;
  logic [N-1:0]   w_d_sr_nxt;

  // Full-subtractor cell on the current LSBs and the running borrow
  assign w_d       = r_a_sr[0] ^ r_b_sr[0] ^ r_brw;
  assign w_brw_nxt = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_brw);

  // Result bits enter at the MSB so that after N cycles bit 0 sits at the LSB
  generate
    if (N == 1) begin : g_d_one
      assign w_d_sr_nxt = w_d;
    end else begin : g_d_many
      assign w_d_sr_nxt = {w_d, r_d_sr[N-1:1]};
    end
  endgenerate

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;
  assign w_last   = (r_cnt == CW'(N - 1));

  // Handshake outputs come straight from the registered state
  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.diff      = r_diff;
  assign bus.bout      = r_bout;
  assign o_state       = r_state;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode: accept in IDLE, leave RUN on the last bit, pop in DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)       w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: load operands on accept, shift one bit per RUN cycle,
  // and capture the finished result on the RUN->DONE edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr <= '0;
      r_b_sr <= '0;
      r_d_sr <= '0;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_accept) begin
      r_a_sr <= bus.a;
      r_b_sr <= bus.b;
      r_brw  <= bus.bin;
      r_cnt  <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sr <= r_a_sr >> 1;
      r_b_sr <= r_b_sr >> 1;
      r_d_sr <= w_d_sr_nxt;
      r_brw  <= w_brw_nxt;
      r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
      if (w_last) begin
        r_diff <= w_d_sr_nxt;
        r_bout <= w_brw_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (N=4).
// Expected results come from plain integer arithmetic: a - b - bin taken
// modulo 2^(N+1), whose top bit is the borrow-out.
module tb_serial_subtractor;

  localparam int N = 4;
  localparam int W = N + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor_if #(.N(N)) bus ();
  logic [1:0] dbg_state;

  serial_subtractor #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .o_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_sub(input int a, input int b, input int bin);
    int r;
    r = a - b - bin;
    return W'(r);
  endfunction

  // ---------------- driver tasks ----------------
  // One full operation: wait for in_ready, accept, measure latency to
  // out_valid, check the result, optionally hold backpressure for `hold`
  // cycles while hammering in_valid with junk operands, then pop.
  task automatic do_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic bin, input int hold);
    logic [W-1:0] e;
    int lat;
    int wait_n;
    e = ref_sub(int'(a), int'(b), int'(bin));
    @(negedge clk);
    wait_n = 0;
    while (!bus.in_ready && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check_val({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_val({tag, "_latency"}, 32'(lat), 32'(N + 1));
    check_val({tag, "_result"}, 32'({bus.bout, bus.diff}), 32'(e));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.a = N'($urandom_range(0, (1 << N) - 1));
      bus.b = N'($urandom_range(0, (1 << N) - 1));
      bus.bin = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      check_val({tag, "_bp_valid"}, 32'(bus.out_valid), 32'd1);
      check_val({tag, "_bp_ready"}, 32'(bus.in_ready), 32'd0);
      check_val({tag, "_bp_result"}, 32'({bus.bout, bus.diff}), 32'(e));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    check_val({tag, "_pop_valid"}, 32'(bus.out_valid), 32'd0);
    check_val({tag, "_pop_ready"}, 32'(bus.in_ready), 32'd1);
    check_val({tag, "_pop_hold"}, 32'({bus.bout, bus.diff}), 32'(e));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] e;
    logic [8:0]   v;
    int idx;
    int guard;
    int last_acc;

    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_val("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check_val("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("reset_result", 32'({bus.bout, bus.diff}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corners
    do_op("t1", 4'b0000, 4'b1111, 1'b0, 0);
    do_op("t2", 4'b1111, 4'b0000, 1'b1, 0);
    do_op("t3a", 4'b0101, 4'b0101, 1'b1, 0);
    do_op("t3b", 4'b0101, 4'b0101, 1'b0, 0);

    // Backpressure with in_valid driven throughout
    do_op("t4", 4'b1010, 4'b0011, 1'b1, 6);

    // Reset in the middle of RUN: result must never appear
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 4'b0010;
    bus.b = 4'b1001;
    bus.bin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("t5_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_val("t5_rst_result", 32'({bus.bout, bus.diff}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val("t5_no_stale_valid", 32'(bus.out_valid), 32'd0);
    end
    do_op("t5_next", 4'b1000, 4'b0001, 1'b0, 0);

    // Random operations with random backpressure
    for (int i = 0; i < 16; i++) begin
      do_op("rand", N'($urandom_range(0, (1 << N) - 1)), N'($urandom_range(0, (1 << N) - 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    // Exhaustive back-to-back sweep, consumer always ready
    bus.out_ready = 1'b1;
    idx = 0;
    guard = 0;
    last_acc = -1;
    while ((idx < 512 || exp_q.size() > 0) && guard < 6000) begin
      @(negedge clk);
      guard++;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check_val("exh_spurious_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("exh_result", 32'({bus.bout, bus.diff}), 32'(e));
        end
      end
      if (bus.in_ready && idx < 512) begin
        v = idx[8:0];
        bus.a = v[3:0];
        bus.b = v[7:4];
        bus.bin = v[8];
        bus.in_valid = 1'b1;
        exp_q.push_back(ref_sub(int'(v[3:0]), int'(v[7:4]), int'(v[8])));
        if (last_acc >= 0) check_val("exh_spacing", 32'(cyc - last_acc), 32'd6);
        last_acc = cyc;
        idx++;
      end else if (idx >= 512) begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check_val("exh_all_issued", 32'(idx), 32'd512);
    check_val("exh_all_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
